// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared segment type, blank pattern and active-low hex table
//               for the multiplexed 7-segment driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Bit order {g,f,e,d,c,b,a}, 0 = segment lit (common-anode).
    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage
`default_nettype wire

// File: rtl/hex7seg_dec.sv
`default_nettype none
// ============================================================================
// Module      : hex7seg_dec
// Description : Combinational nibble to active-low 7-segment pattern lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module hex7seg_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule
`default_nettype wire

// File: rtl/seg7_mux_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_mux_driver
// Description : Time-multiplexed N-digit common-anode 7-segment driver with
//               frame-synchronous double buffering, LZB, PWM and anti-ghost.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BRIGHT_W    = 3
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    lzb_i,
    input  logic                    load_i,
    input  logic [BRIGHT_W-1:0]     brightness_i,
    output logic [6:0]              seg_n_o,
    output logic                    dp_n_o,
    output logic [NUM_DIGITS-1:0]   an_n_o,
    output logic                    frame_done_o
);

    localparam int                  STEP        = REFRESH_DIV / (2**BRIGHT_W);
    localparam int                  SLOT_W      = $clog2(REFRESH_DIV);
    localparam int                  DIG_W       = $clog2(NUM_DIGITS);
    localparam logic [SLOT_W-1:0]   SLOT_LAST   = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0]    DIG_LAST    = DIG_W'(NUM_DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = '1;

    logic [SLOT_W-1:0]       slot_q,  slot_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] sh_value_q, disp_value_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q,    disp_dp_q;
    logic                    sh_lzb_q,   disp_lzb_q;
    seg_t                    seg_n_q,    seg_n_d;
    logic                    dp_n_q,     dp_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q,     an_n_d;
    logic                    frame_done_q;

    logic                    boundary;
    logic                    digit_on;
    logic [3:0]              nib;
    logic                    dp_sel;
    logic                    blank_sel;
    seg_t                    dec_seg;

    always_comb begin
        boundary = (slot_q == SLOT_LAST) && (digit_q == DIG_LAST);
        slot_d   = slot_q + SLOT_W'(1);
        digit_d  = digit_q;
        if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
        end
    end

    // Slot 0 of every digit stays dark so the anode switch never overlaps
    // the previous digit's segment pattern.
    assign digit_on = (slot_q != '0) &&
                      ((brightness_i == BRIGHT_FULL) ||
                       (int'(slot_q) < int'(brightness_i) * STEP));

    always_comb begin
        nib       = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q == DIG_W'(i)) begin
                nib       = disp_value_q[4*i +: 4];
                dp_sel    = disp_dp_q[i];
                blank_sel = (i != 0) && disp_lzb_q &&
                            ((disp_value_q >> (4*i)) == '0);
            end
        end
    end

    hex7seg_dec u_dec (
        .nibble_i (nib),
        .seg_o    (dec_seg)
    );

    always_comb begin
        seg_n_d = SEG_BLANK;
        dp_n_d  = 1'b1;
        an_n_d  = '1;
        if (digit_on) begin
            an_n_d  = ~(NUM_DIGITS'(1) << digit_q);
            seg_n_d = blank_sel ? SEG_BLANK : dec_seg;
            dp_n_d  = ~dp_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= '0;
            digit_q      <= '0;
            sh_value_q   <= '0;
            sh_dp_q      <= '0;
            sh_lzb_q     <= 1'b0;
            disp_value_q <= '0;
            disp_dp_q    <= '0;
            disp_lzb_q   <= 1'b0;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            digit_q      <= digit_d;
            if (load_i) begin
                sh_value_q <= value_i;
                sh_dp_q    <= dp_i;
                sh_lzb_q   <= lzb_i;
            end
            // Non-blocking read gives the pre-edge shadow on a coincident load.
            if (boundary) begin
                disp_value_q <= sh_value_q;
                disp_dp_q    <= sh_dp_q;
                disp_lzb_q   <= sh_lzb_q;
            end
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= boundary;
        end
    end

    assign seg_n_o      = seg_n_q;
    assign dp_n_o       = dp_n_q;
    assign an_n_o       = an_n_q;
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_mux_driver
// Description : Self-checking bench for seg7_mux_driver (4 digits, 8-cycle slots).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_mux_driver;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int BW    = 2;
    localparam int STEP  = RD / (2**BW);
    localparam int FRAME = N * RD;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [4*N-1:0]  value_i = '0;
    logic [N-1:0]    dp_i = '0;
    logic            lzb_i = 1'b0;
    logic            load_i = 1'b0;
    logic [BW-1:0]   brightness_i = '1;
    logic [6:0]      seg_n_o;
    logic            dp_n_o;
    logic [N-1:0]    an_n_o;
    logic            frame_done_o;

    int checks   = 0;
    int failures = 0;

    // Model state: cycles since reset release, shadow and displayed contents.
    int              t;
    logic [15:0]     sh_val, d_val;
    logic [3:0]      sh_dp,  d_dp;
    logic            sh_lzb, d_lzb;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_mux_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .BRIGHT_W    (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .value_i      (value_i),
        .dp_i         (dp_i),
        .lzb_i        (lzb_i),
        .load_i       (load_i),
        .brightness_i (brightness_i),
        .seg_n_o      (seg_n_o),
        .dp_n_o       (dp_n_o),
        .an_n_o       (an_n_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        sh_val = '0; sh_dp = '0; sh_lzb = 1'b0;
        d_val  = '0; d_dp  = '0; d_lzb  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_seg_n"}, 32'(seg_n_o), 32'h7F);
        check({where, "_dp_n"},  32'(dp_n_o),  32'h1);
        check({where, "_an_n"},  32'(an_n_o),  32'hF);
        check({where, "_fd"},    32'(frame_done_o), 32'h0);
    endtask

    // One clock: predict the outputs produced by this edge, then advance the model.
    task automatic step();
        int         slot, dig, upper;
        logic [6:0] es;
        logic       edp, efd, blank;
        logic [3:0] ean, nb;
        slot = t % RD;
        dig  = (t / RD) % N;
        efd  = (slot == RD - 1) && (dig == N - 1);
        es = 7'h7F; edp = 1'b1; ean = 4'hF;
        if (slot != 0 && (brightness_i == 2'd3 || slot < int'(brightness_i) * STEP)) begin
            ean   = 4'hF ^ (4'b0001 << dig);
            nb    = d_val[4*dig +: 4];
            upper = int'(d_val) >> (4 * dig);
            blank = d_lzb && (dig > 0) && (upper == 0);
            es    = blank ? 7'h7F : hex_tab[nb];
            edp   = ~d_dp[dig];
        end
        @(posedge clk);
        #1;
        check("seg_n", 32'(seg_n_o), 32'(es));
        check("dp_n",  32'(dp_n_o),  32'(edp));
        check("an_n",  32'(an_n_o),  32'(ean));
        check("frame_done", 32'(frame_done_o), 32'(efd));
        if (efd) begin
            d_val = sh_val; d_dp = sh_dp; d_lzb = sh_lzb;
        end
        if (load_i) begin
            sh_val = value_i; sh_dp = dp_i; sh_lzb = lzb_i;
        end
        t++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic load_once(input logic [15:0] v, input logic [3:0] d, input logic z);
        value_i = v; dp_i = d; lzb_i = z; load_i = 1'b1;
        step();
        load_i = 1'b0;
    endtask

    initial begin
        model_reset();

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("rst_held");
        rst = 1'b0;
        model_reset();

        // Power-on contents: all digits show 0, no blanking.
        brightness_i = 2'd3;
        run(2 * FRAME);

        // Mixed hex digits with a decimal point on digit 2.
        load_once(16'h12AF, 4'b0100, 1'b0);
        run(2 * FRAME);

        // Leading-zero blanking.
        load_once(16'h0070, 4'b0000, 1'b1);
        run(2 * FRAME);

        // PWM: minimum non-zero brightness, then dark.
        brightness_i = 2'd1;
        run(FRAME + 3);
        brightness_i = 2'd0;
        run(FRAME + 5);
        brightness_i = 2'd2;
        run(FRAME);
        brightness_i = 2'd3;

        // Loads one cycle before and exactly on the frame boundary.
        load_once(16'h1111, 4'b0001, 1'b0);
        while (t % FRAME != FRAME - 2) step();
        load_once(16'h2222, 4'b0010, 1'b0);
        load_once(16'h3333, 4'b1000, 1'b0);
        run(3 * FRAME);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            value_i = 16'($urandom);
            dp_i    = 4'($urandom);
            lzb_i   = 1'($urandom);
            if ($urandom % 3 == 0) value_i = value_i >> (4 * ($urandom % 4));
            load_i  = ($urandom % 7 == 0);
            if ($urandom % 25 == 0) brightness_i = 2'($urandom);
            step();
        end
        load_i = 1'b0;
        brightness_i = 2'd3;
        load_once(16'h9C05, 4'b0101, 1'b1);
        run(FRAME);

        // Asynchronous reset mid-slot of digit 2.
        while (!(((t / RD) % N) == 2 && (t % RD) == 3)) step();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
